pipe_rx_skid: RTL and testbench

- Reader end of the inter-stage pipe protocol. Sits between a pipe's output (valid/data/read) and the consuming stage's logic.
- Pops the pipe only when it has room, then re-presents data to the stage over a registered valid/ready interface through a 2-entry skid buffer.
- Sustains 1 transfer/clock with no combinational path from stage_ready_in to pipe_read_out.
- Provides a synchronous flush for branch/exception squash.

---
 rtl/cpu_params_pkg.sv | 4 +
 rtl/cpu_structs_pkg.sv | 4 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_rx_skid.sv | 113 +++++++++++
 tb/tb_pipe_rx_skid.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// Shared CPU build parameters.
package cpu_params_pkg;
  localparam int PIPE_RX_CNT_W = 16;
endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared CPU type definitions: state encoding of the pipe reader skid buffer.
package cpu_structs_pkg;
  typedef enum logic [1:0] {RX_EMPTY = 2'd0, RX_ONE = 2'd1, RX_TWO = 2'd2} rx_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_rx_skid.sv
// Pipe reader: pops the pipe only when there is room and re-presents entries to the stage
// through a registered 2-entry skid buffer. Statistics/assertions built when PIPE_RX_STATS_EN is defined.
module pipe_rx_skid
  import cpu_structs_pkg::*;
  import cpu_params_pkg::*;
#(
  parameter type T     = logic [31:0],
  parameter int  CNT_W = PIPE_RX_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             pipe_valid_in,
  input  T                 pipe_data_in,
  output logic             pipe_read_out,
  output logic             stage_valid_out,
  output T                 stage_data_out,
  input  logic             stage_ready_in,
  input  logic             flush_in,
  output logic [1:0]       level_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] xfer_cnt_out
);

  rx_state_t state_q, state_d;
  T          head_q, head_d;
  T          tail_q, tail_d;
  logic      rd;
  logic      acc;

  // Pop decision uses only registered state, so stage_ready_in never reaches pipe_read_out.
  assign rd  = pipe_valid_in & reset_in & ~flush_in & (state_q != RX_TWO);
  assign acc = stage_valid_out & stage_ready_in;

  assign pipe_read_out   = rd;
  assign stage_valid_out = (state_q != RX_EMPTY);
  assign stage_data_out  = head_q;
  assign level_out       = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_in) begin
      state_d = RX_EMPTY;
    end else begin
      unique case (state_q)
        RX_EMPTY: begin
          if (rd) begin
            head_d  = pipe_data_in;
            state_d = RX_ONE;
          end
        end
        RX_ONE: begin
          if (rd && acc) begin
            head_d = pipe_data_in;
          end else if (rd) begin
            tail_d  = pipe_data_in;
            state_d = RX_TWO;
          end else if (acc) begin
            state_d = RX_EMPTY;
          end
        end
        RX_TWO: begin
          if (acc) begin
            head_d  = tail_q;
            state_d = RX_ONE;
          end
        end
        default: state_d = RX_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= RX_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef PIPE_RX_STATS_EN
  sat_counter #(.W(CNT_W)) u_xfer_cnt (
    .clk   (clk_in),
    .clr_n (reset_in),
    .en    (acc),
    .cnt   (xfer_cnt_out)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_in),
    .clr_n (reset_in),
    .en    (stage_valid_out & ~stage_ready_in),
    .cnt   (stall_cnt_out)
  );

  always @(negedge clk_in) begin
    if (reset_in) begin
      assert (!pipe_read_out || pipe_valid_in);
      assert (level_out != 2'd3);
      assert (!stage_valid_out || !$isunknown(stage_data_out));
    end
  end
`else
  assign xfer_cnt_out  = '0;
  assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pipe_rx_skid.sv
// Bench for pipe_rx_skid: queue-based reference model checked every cycle plus directed literal checks.
module tb_pipe_rx_skid;

  logic        clk = 1'b0;
  logic        rst_n, pv, fl, rdy;
  logic [31:0] pd;
  logic        rd_o, sv_o;
  logic [31:0] sd_o;
  logic [1:0]  lvl_o;
  logic [15:0] stall_o, xfer_o;
  logic        rd4, sv4;
  logic [31:0] sd4;
  logic [1:0]  lvl4;
  logic [3:0]  stall4, xfer4;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [31:0] mq[$];
  logic [31:0] head_m;
  int xfer_m, stall_m, xfer4_m;
  bit acc_m, rd_m;

  always #5 clk = ~clk;

  pipe_rx_skid dut (
    .clk_in(clk), .reset_in(rst_n), .pipe_valid_in(pv), .pipe_data_in(pd),
    .pipe_read_out(rd_o), .stage_valid_out(sv_o), .stage_data_out(sd_o),
    .stage_ready_in(rdy), .flush_in(fl), .level_out(lvl_o),
    .stall_cnt_out(stall_o), .xfer_cnt_out(xfer_o)
  );

  pipe_rx_skid #(.CNT_W(4)) dut4 (
    .clk_in(clk), .reset_in(rst_n), .pipe_valid_in(pv), .pipe_data_in(pd),
    .pipe_read_out(rd4), .stage_valid_out(sv4), .stage_data_out(sd4),
    .stage_ready_in(rdy), .flush_in(fl), .level_out(lvl4),
    .stall_cnt_out(stall4), .xfer_cnt_out(xfer4)
  );

  function automatic bit exp_rd();
    return pv && rst_n && !fl && (mq.size() < 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffer is a FIFO of at most two entries.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      head_m  = '0;
      xfer_m  = 0;
      stall_m = 0;
      xfer4_m = 0;
    end else begin
      acc_m = (mq.size() > 0) && rdy;
      rd_m  = exp_rd();
      if (acc_m) begin
        if (xfer_m < 65535) xfer_m++;
        if (xfer4_m < 15) xfer4_m++;
      end
      if ((mq.size() > 0) && !rdy && stall_m < 65535) stall_m++;
      if (fl) begin
        mq.delete();
      end else begin
        if (acc_m) void'(mq.pop_front());
        if (rd_m) mq.push_back(pd);
      end
      if (mq.size() > 0) head_m = mq[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pipe_read", {31'b0, rd_o}, {31'b0, exp_rd()});
      chk("stage_valid", {31'b0, sv_o}, {31'b0, mq.size() > 0});
      chk("level", {30'b0, lvl_o}, mq.size());
      chk("stage_data", sd_o, head_m);
`ifdef PIPE_RX_STATS_EN
      chk("xfer_cnt", {16'b0, xfer_o}, xfer_m);
      chk("stall_cnt", {16'b0, stall_o}, stall_m);
      chk("xfer_cnt4", {28'b0, xfer4}, xfer4_m);
`else
      chk("xfer_cnt", {16'b0, xfer_o}, 0);
      chk("stall_cnt", {16'b0, stall_o}, 0);
`endif
    end
  end

  task automatic set(input logic v, input logic [31:0] d, input logic r, input logic f, input logic rs);
    pv = v; pd = d; rdy = r; fl = f; rst_n = rs;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set(1, 32'hDEAD, 0, 0, 0);
    tick(); tick();
    chk_en = 1'b1;
    // reset state
    chk("rst_read", {31'b0, rd_o}, 0);
    chk("rst_valid", {31'b0, sv_o}, 0);
    chk("rst_level", {30'b0, lvl_o}, 0);
    chk("rst_data", sd_o, 0);

    // streaming
    set(1, 32'h1, 1, 0, 1); chk("str_rd0", {31'b0, rd_o}, 1); tick();
    set(1, 32'h2, 1, 0, 1); chk("str_d1", sd_o, 32'h1); chk("str_lvl1", {30'b0, lvl_o}, 1); tick();
    set(1, 32'h3, 1, 0, 1); chk("str_d2", sd_o, 32'h2); chk("str_rd2", {31'b0, rd_o}, 1); tick();
    set(0, 32'h0, 1, 0, 1); chk("str_d3", sd_o, 32'h3); chk("str_lvl3", {30'b0, lvl_o}, 1); tick();
    set(0, 32'h0, 1, 0, 1); chk("str_empty", {31'b0, sv_o}, 0); chk("str_hold", sd_o, 32'h3);

    // backpressure
    set(1, 32'hA, 0, 0, 1); tick();
    set(1, 32'hB, 0, 0, 1); tick();
    set(1, 32'hC, 0, 0, 1); chk("bp_lvl2", {30'b0, lvl_o}, 2); chk("bp_rd0", {31'b0, rd_o}, 0); tick();
    set(1, 32'hC, 1, 0, 1); chk("bp_dA", sd_o, 32'hA); tick();
    set(1, 32'hC, 1, 0, 1); chk("bp_dB", sd_o, 32'hB); chk("bp_rdC", {31'b0, rd_o}, 1); tick();
    set(0, 32'h0, 1, 0, 1); chk("bp_dC", sd_o, 32'hC); chk("bp_vC", {31'b0, sv_o}, 1); tick();

    // flush with full buffer
    set(1, 32'h10, 0, 0, 1); tick();
    set(1, 32'h11, 0, 0, 1); tick();
    set(1, 32'h12, 1, 1, 1); chk("fl_rd0", {31'b0, rd_o}, 0); chk("fl_lvl2", {30'b0, lvl_o}, 2); tick();
    set(1, 32'h12, 1, 0, 1); chk("fl_valid", {31'b0, sv_o}, 0); chk("fl_lvl", {30'b0, lvl_o}, 0); tick();
    set(0, 32'h0, 1, 0, 1); chk("fl_d12", sd_o, 32'h12); tick();

    // reset mid-operation
    set(1, 32'h30, 0, 0, 1); tick();
    set(1, 32'h31, 0, 0, 1); tick();
    set(1, 32'h32, 0, 0, 0); chk("mr_rd", {31'b0, rd_o}, 0); tick();
    set(1, 32'h32, 1, 0, 1);
    chk("mr_valid", {31'b0, sv_o}, 0); chk("mr_lvl", {30'b0, lvl_o}, 0);
    chk("mr_data", sd_o, 0); chk("mr_rd1", {31'b0, rd_o}, 1); tick();
    set(0, 32'h0, 1, 0, 1); chk("mr_d32", sd_o, 32'h32); tick();

    // simultaneous accept and read in ONE
    set(1, 32'h20, 0, 0, 1); tick();
    set(1, 32'h21, 1, 0, 1); chk("sim_rd", {31'b0, rd_o}, 1); chk("sim_d20", sd_o, 32'h20); tick();
    set(0, 32'h0, 1, 0, 1); chk("sim_lvl", {30'b0, lvl_o}, 1); chk("sim_d21", sd_o, 32'h21); tick();

    // statistics: 5 transfers, 3 stalled cycles after a fresh reset
    set(0, 32'h0, 1, 0, 0); tick();
    set(1, 32'h1, 1, 0, 1); tick();
    set(1, 32'h2, 0, 0, 1); tick();
    set(0, 32'h0, 0, 0, 1); tick();
    set(0, 32'h0, 0, 0, 1); tick();
    set(0, 32'h0, 1, 0, 1); tick();
    for (int i = 3; i <= 5; i++) begin
      set(1, i, 1, 0, 1); tick();
    end
    set(0, 32'h0, 1, 0, 1); tick();
    set(0, 32'h0, 1, 0, 1);
`ifdef PIPE_RX_STATS_EN
    chk("stats_xfer", {16'b0, xfer_o}, 5);
    chk("stats_stall", {16'b0, stall_o}, 3);
`else
    chk("stats_xfer", {16'b0, xfer_o}, 0);
    chk("stats_stall", {16'b0, stall_o}, 0);
`endif

    // mixed traffic with a flush and a reset inside
    for (int i = 0; i < 60; i++) begin
      set((i % 3) != 0, 32'h100 + i, (i % 4) != 1, i == 40, i != 50);
      tick();
    end

    // long stream to saturate the narrow counter
    for (int i = 0; i < 20; i++) begin
      set(1, 32'h200 + i, 1, 0, 1);
      tick();
    end
    set(0, 32'h0, 1, 0, 1); tick();
`ifdef PIPE_RX_STATS_EN
    chk("sat_xfer4", {28'b0, xfer4}, 15);
`else
    chk("sat_xfer4", {28'b0, xfer4}, 0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
